// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide controller: op encodings,
// FSM state encodings, iteration count and small op-decoding helpers.
package mdu_pkg;

  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  // Bit 1 of the op selects divide, bit 0 clear means signed.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multi-cycle datapath: a shift-add multiply step or a
// restoring divide step on the {hi, lo} accumulator pair.
//   multiply: lo holds the remaining multiplier bits, i_opnd the multiplicand.
//   divide:   lo holds the remaining dividend bits / growing quotient,
//             hi the partial remainder, i_opnd the divisor.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;

  // Compute both step flavours and select by operation.
  always_comb begin
    w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_shifted = {i_hi, i_lo[WIDTH-1]};
    // Only used when the trial subtraction succeeds, so the result fits WIDTH bits.
    w_diff    = w_shifted[WIDTH-1:0] - i_opnd;
    o_hi      = '0;
    o_lo      = '0;
    if (!i_div) begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end else if (w_shifted >= {1'b0, i_opnd}) begin
      o_hi = w_diff;
      o_lo = {i_lo[WIDTH-2:0], 1'b1};
    end else begin
      o_hi = w_shifted[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_controller.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Sequence: IDLE -> PREP -> ITER x ITERS -> FIX -> DONE -> IDLE.
// Divide by zero goes PREP -> DONE with lo = all ones, hi = dividend.
// Handshake: start is sampled only in IDLE (ignored while busy); done is a
// one-cycle pulse on the edge that loaded hi/lo; flush aborts any non-IDLE
// state without touching hi/lo and beats a simultaneous start in IDLE.
module mult_div_controller
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = MDU_ITERS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hilo_read,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_e       dbg_state
);

  mdu_state_e       r_state;
  mdu_state_e       w_next;
  logic [5:0]       r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_rs;
  logic [WIDTH-1:0] r_rt;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_signed;
  logic             w_div;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_rs_abs;
  logic [WIDTH-1:0] w_rt_abs;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;

  assign w_signed   = op_is_signed(r_op);
  assign w_div      = op_is_div(r_op);
  assign w_div_zero = w_div && (r_rt == '0);
  assign w_rs_abs   = (w_signed && r_rs[WIDTH-1]) ? -r_rs : r_rs;
  assign w_rt_abs   = (w_signed && r_rt[WIDTH-1]) ? -r_rt : r_rt;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (w_div),
    .i_hi   (r_acc_hi),
    .i_lo   (r_acc_lo),
    .i_opnd (r_opnd),
    .o_hi   (w_step_hi),
    .o_lo   (w_step_lo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_PREP;
      ST_PREP: w_next = w_div_zero ? ST_DONE : ST_ITER;
      ST_ITER: if (r_cnt == 6'd1) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (flush) w_next = ST_IDLE;
  end

  // Operand capture, iteration counter, accumulator, sign fix-up and HI/LO load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_opnd    <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_op <= op;
              r_rs <= rs_val;
              r_rt <= rt_val;
            end
          end
          ST_PREP: begin
            r_cnt     <= 6'(ITERS);
            r_neg_res <= w_signed & (r_rs[WIDTH-1] ^ r_rt[WIDTH-1]);
            r_neg_rem <= w_signed & r_rs[WIDTH-1];
            r_acc_hi  <= '0;
            if (w_div_zero) begin
              r_acc_hi <= r_rs;
              r_acc_lo <= '1;
            end else if (w_div) begin
              r_opnd   <= w_rt_abs;
              r_acc_lo <= w_rs_abs;
            end else begin
              r_opnd   <= w_rs_abs;
              r_acc_lo <= w_rt_abs;
            end
          end
          ST_ITER: begin
            r_cnt    <= r_cnt - 6'd1;
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
          end
          ST_FIX: begin
            if (w_div) begin
              if (r_neg_res) r_acc_lo <= -r_acc_lo;
              if (r_neg_rem) r_acc_hi <= -r_acc_hi;
            end else if (r_neg_res) begin
              {r_acc_hi, r_acc_lo} <= -{r_acc_hi, r_acc_lo};
            end
          end
          ST_DONE: begin
            r_hi   <= r_acc_hi;
            r_lo   <= r_acc_lo;
            r_done <= 1'b1;
          end
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign stall     = busy & hilo_read;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_controller.sv
// Bench for mult_div_controller: a scoreboard queue of expected {hi, lo}
// results filled by a reference model when operations are launched and
// drained by a monitor on every done pulse; scenario tasks check latency,
// flush, overlap, reset and stall behaviour inline.
module tb_mult_div_controller;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         flush = 1'b0;
  logic         hilo_read = 1'b0;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo;
  mdu_state_e   dbg_state;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  mult_div_controller #(.WIDTH(W), .ITERS(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .hilo_read (hilo_read),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Reference model: returns {hi, lo}
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [2*W-1:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == '0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == '0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expected result
  always @(posedge clk) begin
    logic [2*W-1:0] e;
    #1;
    if (done) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, required no done", hi, lo);
      end else begin
        e = exp_q.pop_front();
        if ({hi, lo} !== e)
          $display("FAIL result: got hi=%h lo=%h, required hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        else
          pass_cnt++;
      end
    end
  end

  // Driver: launch one operation, wait (bounded) for done, report latency and busy cycles
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcyc);
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    exp_q.push_back(model(o, a, b));
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    bcyc = 0;
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b, required 0", done); else pass_cnt++;
    chk_cnt++; if (hi !== '0) $display("FAIL reset_hi: got %h, required 0", hi); else pass_cnt++;
    chk_cnt++; if (lo !== '0) $display("FAIL reset_lo: got %h, required 0", lo); else pass_cnt++;
    // Release just after a rising edge so the next edge is the first one out of reset
    #15;
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    int lat, bcyc;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bcyc);
    chk_cnt++; if (lat !== 35) $display("FAIL mult_latency: got %0d, required 35", lat); else pass_cnt++;
    chk_cnt++; if (bcyc !== 35) $display("FAIL mult_busy_cycles: got %0d, required 35", bcyc); else pass_cnt++;
  endtask

  task automatic test_multu();
    int lat, bcyc;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc);
    chk_cnt++; if (lat !== 35) $display("FAIL multu_latency: got %0d, required 35", lat); else pass_cnt++;
  endtask

  task automatic test_div();
    int lat, bcyc;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bcyc);
    chk_cnt++; if (lat !== 35) $display("FAIL div_latency: got %0d, required 35", lat); else pass_cnt++;
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
    chk_cnt++; if (lat !== 35) $display("FAIL div_ovf_latency: got %0d, required 35", lat); else pass_cnt++;
  endtask

  task automatic test_divu_zero();
    int lat, bcyc;
    run_op(2'b11, 32'd100, 32'd0, lat, bcyc);
    chk_cnt++; if (lat !== 2) $display("FAIL divz_latency: got %0d, required 2", lat); else pass_cnt++;
    chk_cnt++; if (bcyc !== 2) $display("FAIL divz_busy_cycles: got %0d, required 2", bcyc); else pass_cnt++;
  endtask

  task automatic test_flush();
    int lat, bcyc, dones;
    logic [2*W-1:0] hold;
    run_op(2'b11, 32'd1000, 32'd7, lat, bcyc);
    hold = model(2'b11, 32'd1000, 32'd7);
    // Launch a DIVU that is flushed at cycle 10; nothing is expected from it
    @(negedge clk);
    op = 2'b11; rs_val = 32'h0000_FFFF; rt_val = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b, required 0", busy); else pass_cnt++;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dones++; end
    chk_cnt++; if (dones !== 0) $display("FAIL flush_no_done: got %0d pulses, required 0", dones); else pass_cnt++;
    chk_cnt++; if ({hi, lo} !== hold) $display("FAIL flush_hilo: got %h, required %h", {hi, lo}, hold); else pass_cnt++;
    // flush together with start in IDLE: nothing starts
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'b00; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL flush_start_idle: got busy=%b, required 0", busy); else pass_cnt++;
  endtask

  task automatic test_overlap();
    int lat, dones;
    @(negedge clk);
    op = 2'b00; rs_val = 32'h0001_2345; rt_val = 32'hFFFF_FFF7; start = 1'b1;
    exp_q.push_back(model(2'b00, 32'h0001_2345, 32'hFFFF_FFF7));
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; op = 2'b11; rs_val = 32'd77; rt_val = 32'd0;
    @(posedge clk); #1; start = 1'b0;
    lat = 5;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk_cnt++; if (lat !== 35) $display("FAIL overlap_latency: got %0d, required 35", lat); else pass_cnt++;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) dones++; end
    chk_cnt++; if (dones !== 0) $display("FAIL overlap_queued: got %0d active cycles, required 0", dones); else pass_cnt++;
  endtask

  task automatic test_stall();
    int lat;
    hilo_read = 1'b1;
    @(negedge clk);
    op = 2'b01; rs_val = 32'd12345; rt_val = 32'd678; start = 1'b1;
    exp_q.push_back(model(2'b01, 32'd12345, 32'd678));
    @(posedge clk); #1; start = 1'b0;
    chk_cnt++; if (stall !== 1'b1) $display("FAIL stall_busy: got %b, required 1", stall); else pass_cnt++;
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk_cnt++; if (stall !== 1'b0) $display("FAIL stall_idle: got %b, required 0", stall); else pass_cnt++;
    hilo_read = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, bcyc;
    @(negedge clk);
    op = 2'b11; rs_val = 32'hDEAD_BEEF; rt_val = 32'd13; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b, required 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL midreset_done: got %b, required 0", done); else pass_cnt++;
    chk_cnt++; if (hi !== '0) $display("FAIL midreset_hi: got %h, required 0", hi); else pass_cnt++;
    chk_cnt++; if (lo !== '0) $display("FAIL midreset_lo: got %h, required 0", lo); else pass_cnt++;
    chk_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL midreset_state: got %0d, required 0", dbg_state); else pass_cnt++;
    @(posedge clk); #2; rst_n = 1'b1;
    run_op(2'b10, 32'd1000, 32'hFFFF_FFFD, lat, bcyc);
    chk_cnt++; if (lat !== 35) $display("FAIL post_reset_latency: got %0d, required 35", lat); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, bcyc, want;
    logic [1:0] o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      if (i == 0) begin a = 32'h8000_0000; b = 32'd1; o = 2'b10; end
      run_op(o, a, b, lat, bcyc);
      want = (o[1] && b == '0) ? 2 : 35;
      chk_cnt++;
      if (lat !== want) $display("FAIL random_latency op=%0d: got %0d, required %0d", o, lat, want);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_zero();
    test_flush();
    test_overlap();
    test_stall();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mult_div_controller.md
MULT_DIV_CONTROLLER -- requirements
Module: mult_div_controller

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width in bits.
REQ-002 Parameter ITERS, default 32: iteration count; SHALL equal WIDTH.
REQ-003 clk  in  1  single clock for the block; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request a new operation; sampled only in IDLE.
REQ-006 op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 rs_val  in  WIDTH  multiplicand or dividend.
REQ-008 rt_val  in  WIDTH  multiplier or divisor.
REQ-009 flush  in  1  abort the in-flight operation (pipeline flush).
REQ-010 hilo_read  in  1  an instruction in decode reads HI or LO (MFHI/MFLO).
REQ-011 busy  out  1  operation in progress (any state other than IDLE).
REQ-012 done  out  1  one-cycle pulse: HI/LO were updated on this edge.
REQ-013 stall  out  1  equals busy AND hilo_read; holds the pipeline front end.
REQ-014 hi  out  WIDTH  HI register: high product, or remainder.
REQ-015 lo  out  WIDTH  LO register: low product, or quotient.

Function
REQ-016 FSM states SHALL be: IDLE, PREP, ITER, FIX, DONE.
REQ-017 IDLE -> PREP on an edge with start=1; op, rs_val and rt_val SHALL be captured on that edge.
REQ-018 PREP (1 cycle): for signed ops, take absolute values and record the result signs.
REQ-019 PREP -> DONE directly when op is DIV or DIVU and the divisor is 0.
REQ-020 ITER SHALL run exactly ITERS cycles, driven by a 6-bit down-counter.
REQ-021 Multiply step: shift-add, one multiplier bit per cycle.
REQ-022 Divide step: restoring, one quotient bit per cycle.
REQ-023 FIX (1 cycle): signed ops only; two's-complement negate as needed.
- Product: negated when the operand signs differ.
- Quotient: negated when the operand signs differ.
- Remainder: takes the sign of the dividend.
REQ-024 DONE (1 cycle): hi and lo load the result, done=1, then return to IDLE.
REQ-025 Latency: with start sampled at edge 0, done is high in the cycle after edge 35 (PREP + 32 ITER + FIX + DONE).
- Divide-by-zero path: done is high after edge 2.
REQ-026 Divide by zero: lo=all ones, hi=rs_val; no exception is raised.
REQ-027 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-028 start while busy SHALL be ignored; it is neither queued nor corrupting.
REQ-029 flush in any non-IDLE state: return to IDLE on the next edge, no done pulse, hi/lo unchanged.
REQ-030 flush and start together in IDLE: flush wins and no operation starts.
REQ-031 hi and lo SHALL change only in DONE; intermediate values SHALL never be visible on hi/lo.
REQ-032 stall SHALL be combinational from busy and hilo_read.

Reset
REQ-033 rst_n low SHALL immediately force all of the following, including mid-operation:
- state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
REQ-034 The first start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-035 Shared package mdu_pkg SHALL hold the op encodings, the FSM state encodings and the ITERS constant.
REQ-036 One combinational sub-module, mdu_step, SHALL compute a single shift-add or restoring-divide iteration.
REQ-037 The top level SHALL contain only the FSM, counter, operand/accumulator registers, sign fix-up and HI/LO registers.

Verification
REQ-038 MULT: rs=0xFFFFFFFD, rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done after edge 35; busy high for 35 cycles.
REQ-039 MULTU: rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-040 DIV: rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-041 DIVU: rs=100, rt=0 -> lo=0xFFFFFFFF, hi=0x00000064; done after edge 2.
REQ-042 Flush and overlap: flush at cycle 10 of a DIVU -> busy=0 next cycle, no done, hi/lo keep prior values; start asserted during busy -> no effect.
REQ-043 Reset and stall: rst_n pulled low at ITER cycle 20 -> busy, done, hi, lo read 0 immediately; hilo_read=1 during busy -> stall=1, and stall=0 once IDLE.
